// File: rtl/audio_gain_ramp.sv
// Per-channel soft-mute / volume stage: scales PCM samples by a gain that slews toward its target
// at a fixed per-sample step, then rounds and saturates back to the sample width.
module audio_gain_ramp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned RAMP_STEP  = 64
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [GAIN_WIDTH-1:0] gain_target,
  input  logic                  mute_req,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  muted,
  output logic                  ramping
);

  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic [GAIN_WIDTH-1:0] Step = GAIN_WIDTH'(RAMP_STEP);
  localparam logic signed [PW:0] RoundC =
      {{(PW - GAIN_WIDTH + 3){1'b0}}, 1'b1, {(GAIN_WIDTH - 3){1'b0}}};
  localparam logic signed [PW:0] SatMax =
      {{(PW - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PW:0] SatMin =
      {{(PW - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StMuted, StRamp, StSettled} state_e;

  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [GAIN_WIDTH-1:0] tgt_q, tgt_d;
  logic [GAIN_WIDTH-1:0] eff_tgt;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic                  s1_valid_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  state_e                state_q, state_d;
  logic signed [PW:0]    rounded;
  logic signed [PW:0]    shifted;

  // Gain slews only on accepted samples, so ramp length is counted in samples.
  always_comb begin
    eff_tgt = mute_req ? '0 : gain_target;
    gain_d  = gain_q;
    tgt_d   = tgt_q;
    if (in_valid) begin
      tgt_d = eff_tgt;
      if (eff_tgt > gain_q) begin
        gain_d = ((eff_tgt - gain_q) <= Step) ? eff_tgt : gain_q + Step;
      end else if (eff_tgt < gain_q) begin
        gain_d = ((gain_q - eff_tgt) <= Step) ? eff_tgt : gain_q - Step;
      end
    end
  end

  // State is derived from the next gain/target so it lines up with gain_q.
  always_comb begin
    if (gain_d == '0 && tgt_d == '0) begin
      state_d = StMuted;
    end else if (gain_d == tgt_d) begin
      state_d = StSettled;
    end else begin
      state_d = StRamp;
    end
  end

  // The product uses the gain in effect before this sample's update.
  always_comb begin
    prod_d = PW'($signed(in_data)) * PW'($signed({1'b0, gain_q}));
  end

  always_comb begin
    rounded = $signed({prod_q[PW-1], prod_q}) + RoundC;
    shifted = rounded >>> (GAIN_WIDTH - 2);
    if (shifted > SatMax) begin
      out_data_d = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      out_data_d = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      out_data_d = shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      gain_q      <= '0;
      tgt_q       <= '0;
      state_q     <= StMuted;
      prod_q      <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      gain_q      <= gain_d;
      tgt_q       <= tgt_d;
      state_q     <= state_d;
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (in_valid) begin
        prod_q <= prod_d;
      end
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign muted     = (state_q == StMuted);
  assign ramping   = (state_q == StRamp);

endmodule
